// File: rtl/mag_pkg.sv
// Shared types and BCD limits for the microwave-style countdown timer.
package mag_pkg;

   typedef enum logic [1:0] {
      ENTRY = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;
   localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/mag_bcd_down.sv
// One BCD decade: clear, parallel load (keypad shift), or decrement with a
// configurable wrap value and a combinational borrow-out to the next decade.
module mag_bcd_down (
   input  logic       clk,
   input  logic       i_clr,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_en,
   input  logic [3:0] i_wrap,
   output logic [3:0] o_digit,
   output logic       o_borrow
);

   logic [3:0] r_digit;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_digit <= 4'd0;
      end else if (i_load) begin
         r_digit <= i_load_val;
      end else if (i_en) begin
         // Digits above the wrap value (e.g. sec_tens 6..9) simply count down.
         r_digit <= (r_digit == 4'd0) ? i_wrap : r_digit - 4'd1;
      end
   end

   assign o_digit  = r_digit;
   assign o_borrow = i_en && (r_digit == 4'd0);

endmodule

// File: rtl/mag_timer.sv
// Keypad-loaded MM:SS countdown timer gated by the magnetron latch, with a
// done level and a one-cycle beep when a run reaches 0:00.
module mag_timer
   import mag_pkg::*;
#(
   parameter int CYCLES_PER_SEC = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       clearn,
   input  logic       mag_on,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       timer_done,
   output logic       beep,
   output state_t     o_state
);

   localparam int PRESC_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_SEC - 1);

   state_t             r_state;
   logic [PRESC_W-1:0] r_presc;
   logic               r_done;
   logic               r_beep;

   logic       w_clr;
   logic       w_key_ok;
   logic       w_shift_zero;
   logic       w_next_zero;
   logic       w_time_one;
   logic       w_tick;
   logic [3:0] w_mt, w_mo, w_st, w_so;
   logic       w_b_so, w_b_st, w_b_mo, w_b_mt;

   assign w_clr        = rst || !clearn;
   assign w_key_ok     = key_valid && (key_digit <= BCD_MAX_DIGIT) && (r_state == ENTRY);
   assign w_shift_zero = (w_mo == 4'd0) && (w_st == 4'd0) && (w_so == 4'd0) && (key_digit == 4'd0);
   assign w_next_zero  = w_key_ok ? w_shift_zero : r_done;
   assign w_time_one   = {w_mt, w_mo, w_st, w_so} == 16'h0001;
   // r_done mirrors "all digits zero", so it also blocks decrement from 0:00.
   assign w_tick       = (r_state == RUN) && (r_presc == PRESC_LAST) && !r_done;

   mag_bcd_down u_sec_ones (
      .clk(clk), .i_clr(w_clr), .i_load(w_key_ok), .i_load_val(key_digit),
      .i_en(w_tick), .i_wrap(BCD_MAX_DIGIT), .o_digit(w_so), .o_borrow(w_b_so)
   );
   mag_bcd_down u_sec_tens (
      .clk(clk), .i_clr(w_clr), .i_load(w_key_ok), .i_load_val(w_so),
      .i_en(w_b_so), .i_wrap(BCD_MAX_SEC_TENS), .o_digit(w_st), .o_borrow(w_b_st)
   );
   mag_bcd_down u_min_ones (
      .clk(clk), .i_clr(w_clr), .i_load(w_key_ok), .i_load_val(w_st),
      .i_en(w_b_st), .i_wrap(BCD_MAX_DIGIT), .o_digit(w_mo), .o_borrow(w_b_mo)
   );
   mag_bcd_down u_min_tens (
      .clk(clk), .i_clr(w_clr), .i_load(w_key_ok), .i_load_val(w_mo),
      .i_en(w_b_mo), .i_wrap(BCD_MAX_DIGIT), .o_digit(w_mt), .o_borrow(w_b_mt)
   );

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_state <= ENTRY;
         r_presc <= '0;
         r_done  <= 1'b1;
         r_beep  <= 1'b0;
      end else begin
         r_beep <= 1'b0;
         case (r_state)
            ENTRY: begin
               r_presc <= '0;
               if (w_key_ok) r_done <= w_shift_zero;
               if (mag_on && !w_next_zero) r_state <= RUN;
            end
            RUN: begin
               if (w_tick) begin
                  // The terminal-count decrement lands even if mag_on just dropped.
                  r_presc <= '0;
                  if (w_time_one) begin
                     r_state <= ENTRY;
                     r_done  <= 1'b1;
                     r_beep  <= 1'b1;
                  end else if (!mag_on) begin
                     r_state <= PAUSE;
                  end
               end else if (!mag_on) begin
                  r_presc <= '0;
                  r_state <= PAUSE;
               end else begin
                  r_presc <= r_presc + PRESC_W'(1);
               end
            end
            PAUSE: begin
               r_presc <= '0;
               if (mag_on) r_state <= RUN;
            end
            default: begin
               r_state <= ENTRY;
               r_presc <= '0;
            end
         endcase
      end
   end

   assign min_tens   = w_mt;
   assign min_ones   = w_mo;
   assign sec_tens   = w_st;
   assign sec_ones   = w_so;
   assign timer_done = r_done;
   assign beep       = r_beep;
   assign o_state    = r_state;

   logic w_unused;
   assign w_unused = w_b_mt;

endmodule

// File: tb/tb_mag_timer.sv
// Directed bench for mag_timer: status snapshots and beep events flow through
// expected queues that a negedge monitor drains and compares.
module tb_mag_timer;
   import mag_pkg::*;

   localparam int W = 19;

   logic       clk = 1'b0;
   logic       rst, key_valid, clearn, mag_on;
   logic [3:0] key_digit;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       timer_done, beep;
   state_t     o_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_cnt  = 0;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           beep_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   mag_timer #(.CYCLES_PER_SEC(4)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
      .clearn(clearn), .mag_on(mag_on),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .timer_done(timer_done), .beep(beep), .o_state(o_state)
   );

   function automatic logic [W-1:0] snap(input logic [3:0] mt, input logic [3:0] mo,
                                         input logic [3:0] st, input logic [3:0] so,
                                         input logic done, input state_t s);
      return {mt, mo, st, so, done, s};
   endfunction

   // Monitor: status snapshots on request, beep pulses whenever they appear.
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      int           eb;
      if (exp_q.size() != 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {min_tens, min_ones, sec_tens, sec_ones, timer_done, o_state};
         n_checks = n_checks + 1;
         if (a !== e) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h%h:%h%h done=%b state=%0d, expected %h%h:%h%h done=%b state=%0d",
                     nm, a[18:15], a[14:11], a[10:7], a[6:3], a[2], a[1:0],
                     e[18:15], e[14:11], e[10:7], e[6:3], e[2], e[1:0]);
         end
      end
      if (beep === 1'b1) begin
         n_checks = n_checks + 1;
         if (beep_q.size() == 0) begin
            n_errors = n_errors + 1;
            $display("FAIL beep_unexpected: beep at cycle %0d, expected none", cyc_cnt);
         end else begin
            eb = beep_q.pop_front();
            if (eb != cyc_cnt) begin
               n_errors = n_errors + 1;
               $display("FAIL beep_time: beep at cycle %0d, expected cycle %0d", cyc_cnt, eb);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [W-1:0] e);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      #1;
   endtask

   task automatic key(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      cyc(1);
      key_valid = 1'b0;
      key_digit = 4'd0;
   endtask

   task automatic clear();
      clearn = 1'b0;
      cyc(1);
      clearn = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_digit = 4'd0; clearn = 1'b1; mag_on = 1'b0;
      cyc(2);
      check("reset_hold", snap(0, 0, 0, 0, 1'b1, ENTRY));
      rst = 1'b0;
      cyc(1);
      check("reset_release", snap(0, 0, 0, 0, 1'b1, ENTRY));

      key(1); key(3); key(0);
      check("key_130", snap(0, 1, 3, 0, 1'b0, ENTRY));

      // 0:03 countdown: decrements at 4, 8, 12 cycles after RUN entry.
      clear();
      check("clear_entry", snap(0, 0, 0, 0, 1'b1, ENTRY));
      key(3);
      check("load_003", snap(0, 0, 0, 3, 1'b0, ENTRY));
      mag_on = 1'b1;
      beep_q.push_back(cyc_cnt + 13);
      cyc(1);
      check("run_entry", snap(0, 0, 0, 3, 1'b0, RUN));
      cyc(3);
      check("before_tick1", snap(0, 0, 0, 3, 1'b0, RUN));
      cyc(1);
      check("tick1", snap(0, 0, 0, 2, 1'b0, RUN));
      cyc(4);
      check("tick2", snap(0, 0, 0, 1, 1'b0, RUN));
      cyc(4);
      check("tick3_zero", snap(0, 0, 0, 0, 1'b1, ENTRY));
      cyc(2);
      check("zero_stays_entry", snap(0, 0, 0, 0, 1'b1, ENTRY));
      mag_on = 1'b0;

      // 1:00 borrows to 0:59.
      key(1); key(0); key(0);
      check("load_100", snap(0, 1, 0, 0, 1'b0, ENTRY));
      mag_on = 1'b1;
      cyc(5);
      check("borrow_059", snap(0, 0, 5, 9, 1'b0, RUN));
      mag_on = 1'b0;
      clear();

      // 0:99 counts straight down as decimal 99..0.
      key(9); key(9);
      check("load_099", snap(0, 0, 9, 9, 1'b0, ENTRY));
      mag_on = 1'b1;
      beep_q.push_back(cyc_cnt + 1 + 99 * 4);
      cyc(1);
      for (int i = 1; i <= 99; i++) begin
         cyc(4);
         check($sformatf("cnt99_step%0d", i),
               snap(0, 0, 4'((99 - i) / 10), 4'((99 - i) % 10), i == 99, (i == 99) ? ENTRY : RUN));
      end
      mag_on = 1'b0;

      // Pause holds time, ignores keys, resumes with a fresh 4-cycle second.
      key(1); key(0);
      mag_on = 1'b1;
      cyc(9);
      check("run_two_008", snap(0, 0, 0, 8, 1'b0, RUN));
      mag_on = 1'b0;
      cyc(1);
      check("pause_enter", snap(0, 0, 0, 8, 1'b0, PAUSE));
      key(5);
      cyc(18);
      check("pause_hold", snap(0, 0, 0, 8, 1'b0, PAUSE));
      mag_on = 1'b1;
      cyc(1);
      check("resume", snap(0, 0, 0, 8, 1'b0, RUN));
      key(6);
      cyc(2);
      check("run_key_ignored", snap(0, 0, 0, 8, 1'b0, RUN));
      mag_on = 1'b0;
      cyc(1);
      check("drop_at_tick", snap(0, 0, 0, 7, 1'b0, PAUSE));
      clear();

      // Clear coinciding with terminal count wins, no beep.
      key(5);
      mag_on = 1'b1;
      cyc(4);
      clearn = 1'b0;
      cyc(1);
      check("clear_at_tick", snap(0, 0, 0, 0, 1'b1, ENTRY));
      clearn = 1'b1;
      mag_on = 1'b0;
      key(12);
      check("bad_key_zero", snap(0, 0, 0, 0, 1'b1, ENTRY));
      key(7); key(12);
      check("bad_key_007", snap(0, 0, 0, 7, 1'b0, ENTRY));
      clear();

      // Reset mid-RUN at 2:30, then confirm the prescaler restarted from 0.
      key(2); key(3); key(0);
      check("load_230", snap(0, 2, 3, 0, 1'b0, ENTRY));
      mag_on = 1'b1;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      check("rst_in_run", snap(0, 0, 0, 0, 1'b1, ENTRY));
      rst = 1'b0;
      mag_on = 1'b0;
      key(2);
      mag_on = 1'b1;
      cyc(4);
      check("after_rst_pre", snap(0, 0, 0, 2, 1'b0, RUN));
      cyc(1);
      check("after_rst_tick", snap(0, 0, 0, 1, 1'b0, RUN));
      mag_on = 1'b0;
      cyc(1);
      check("after_rst_pause", snap(0, 0, 0, 1, 1'b0, PAUSE));

      cyc(5);
      n_checks = n_checks + 1;
      if (beep_q.size() != 0) begin
         n_errors = n_errors + 1;
         $display("FAIL beep_missing: %0d beeps outstanding, expected 0", beep_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mag_timer.md
MAG_TIMER -- requirements
Module: mag_timer

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_SEC, default 50000000, meaning clk cycles per one-second countdown step.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port key_valid  input  1  one-cycle strobe: key_digit holds a keypad digit.
REQ-005 The block SHALL have port key_digit  input  4  keypad digit, BCD.
REQ-006 The block SHALL have port clearn  input  1  clear request, active-low.
REQ-007 The block SHALL have port mag_on  input  1  magnetron latch output; high enables countdown.
REQ-008 The block SHALL have ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time remaining, for display.
REQ-009 The block SHALL have port timer_done  output  1  level, high whenever all four digits are zero.
REQ-010 The block SHALL have port beep  output  1  one-cycle pulse on reaching zero by countdown.

Function
REQ-011 The block SHALL implement FSM states ENTRY, RUN, PAUSE.
REQ-012 ENTRY -> RUN when mag_on=1 and time nonzero; RUN -> PAUSE when mag_on=0 and time nonzero; PAUSE -> RUN when mag_on=1; RUN -> ENTRY when time reaches zero.
REQ-013 In ENTRY only, key_valid with key_digit<=9 SHALL shift digits left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit) on the next edge; old min_tens discarded.
REQ-014 key_valid with key_digit>9, or in RUN/PAUSE, SHALL be ignored.
REQ-015 clearn=0 SHALL zero all digits and force ENTRY on the next edge in any state, with priority over key entry and countdown.
REQ-016 A prescaler SHALL count 0..CYCLES_PER_SEC-1 only in RUN; it SHALL be held at 0 outside RUN, so the first decrement occurs CYCLES_PER_SEC cycles after entering RUN.
REQ-017 On prescaler terminal count the time SHALL decrement by one second: sec_ones 0->9 with borrow; sec_tens 0->5 with borrow; min_ones 0->9 with borrow; min_tens decrements.
REQ-018 Entered sec_tens values 6..9 SHALL be legal and count down unchanged (0:99 reaches 0:00 after 99 steps).
REQ-019 Decrement SHALL never occur from 0:00; no wrap to 99:59.
REQ-020 timer_done SHALL be registered, asserted in the same cycle the digits become zero.
REQ-021 beep SHALL pulse for exactly one cycle, coincident with the timer_done rising edge, only for a RUN countdown to zero (not for clear or reset).
REQ-022 If clearn=0 coincides with a terminal count, clear SHALL win and beep SHALL stay 0.
REQ-023 mag_on falling in the same cycle as terminal count SHALL still apply that decrement.

Reset
REQ-024 rst=1 SHALL set state ENTRY, prescaler 0, all digits 0, timer_done=1, beep=0 on the next edge.
REQ-025 rst SHALL have priority over clearn, key entry and countdown, including mid-RUN.

Structure
REQ-026 Package mag_pkg SHALL hold the state typedef (ENTRY, RUN, PAUSE) and BCD constants (max digit 9, max seconds-tens 5).
REQ-027 A sub-module mag_bcd_down SHALL implement one BCD decade down-counter (enable, configurable wrap value, borrow-out); four instances SHALL be chained.

Verification (CYCLES_PER_SEC=4)
REQ-028 Reset, then key 1,3,0 -> digits 0,1,3,0, timer_done=0, state ENTRY.
REQ-029 Load 0:03, mag_on=1 -> decrements at cycles 4,8,12 after RUN entry; at cycle 12 digits 0:00, timer_done=1, beep one cycle, state ENTRY.
REQ-030 Load 1:00, run one step -> 0:59; load 0:99 -> reaches 0:00 after 99 steps without passing through 9:59.
REQ-031 Load 0:10, run 2 steps, mag_on=0 for 20 cycles -> holds 0:08, PAUSE, keys ignored; mag_on=1 -> next decrement 4 cycles later.
REQ-032 clearn=0 mid-RUN at 0:05 coinciding with terminal count -> 0:00, ENTRY, beep=0; key_digit=12 strobed in ENTRY -> digits unchanged.
REQ-033 rst=1 in RUN at 2:30 -> next edge 0:00, timer_done=1, beep=0, prescaler 0.
